l1_req_txn_seq: RTL

- Sequential transaction controller for CPU-side requests into the L1.
- Accepts one CPU request at a time, classifies it as hit or miss from the tag lookup result, and drives the combinational L1 request FSM with `req_status`, `req_curSt` and the latched `sursp_rsp`.
- Issues the downstream snoop request chosen by that FSM and waits for the snoop response.
- Commits the block state the FSM returns, then completes the CPU response handshake.

---
 rtl/l1_req_txn_seq_pkg.sv | 45 ++++
 rtl/l1_req_timeout_cnt.sv | 30 +++
 rtl/l1_req_txn_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/l1_req_txn_seq_pkg.sv
// Shared encodings for the L1 CPU-request sequencer: sequencer states, req_status bits,
// MESI block states and the downstream snoop request / response opcodes.
package l1_req_txn_seq_pkg;

  typedef enum logic [2:0] {
    REQ_IDLE       = 3'd0,
    REQ_LOOKUP     = 3'd1,
    REQ_SDREQ      = 3'd2,
    REQ_WAIT_SURSP = 3'd3,
    REQ_RSP_CURSP  = 3'd4,
    REQ_ERR        = 3'd5
  } req_state_e;

  localparam int READ_HIT   = 0;
  localparam int WRITE_HIT  = 1;
  localparam int READ_MISS  = 2;
  localparam int WRITE_MISS = 3;

  localparam logic [2:0] INVALID   = 3'd0;
  localparam logic [2:0] SHARED    = 3'd1;
  localparam logic [2:0] EXCLUSIVE = 3'd2;
  localparam logic [2:0] MODIFIED  = 3'd3;

  localparam logic [2:0] SDREQ_NONE = 3'd0;
  localparam logic [2:0] SDREQ_RD   = 3'd1;
  localparam logic [2:0] SDREQ_RDX  = 3'd2;
  localparam logic [2:0] SDREQ_INV  = 3'd3;

  localparam logic [2:0] SURSP_NONE  = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;
  localparam logic [2:0] SURSP_SNOOP = 3'd2;

  function automatic logic [3:0] req_status_enc(input logic wr, input logic hit);
    logic [3:0] s;
    s = '0;
    case ({wr, hit})
      2'b01:   s[READ_HIT]   = 1'b1;
      2'b11:   s[WRITE_HIT]  = 1'b1;
      2'b00:   s[READ_MISS]  = 1'b1;
      default: s[WRITE_MISS] = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/l1_req_timeout_cnt.sv
// 8-bit wait counter for the snoop-response phase; lim_o flags the increment that
// would reach LIMIT.
module l1_req_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic lim_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lim_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/l1_req_txn_seq.sv
// CPU-side L1 request sequencer: lookup classification, downstream snoop request,
// snoop-response wait with timeout, block-state commit and CPU response handshake.
module l1_req_txn_seq
  import l1_req_txn_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpreq_valid,
  output logic                  cpreq_ready,
  input  logic                  cpreq_op,
  input  logic [ADDR_WIDTH-1:0] cpreq_addr,
  input  logic                  lkup_hit,
  input  logic [2:0]            blk_curSt,
  output logic [3:0]            req_status,
  output logic [2:0]            req_curSt,
  output logic [2:0]            sursp_rsp,
  input  logic [2:0]            blk_nxtSt,
  input  logic [2:0]            init_sdreq,
  output logic                  sdreq_valid,
  input  logic                  sdreq_ready,
  output logic [2:0]            sdreq_op,
  output logic [ADDR_WIDTH-1:0] sdreq_addr,
  input  logic                  sursp_valid,
  input  logic [2:0]            sursp_in,
  output logic                  cursp_valid,
  input  logic                  cursp_ready,
  output logic                  blk_wr_en,
  output logic [2:0]            blk_wr_st,
  output logic                  timeout_err
);

  req_state_e            state_q;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            status_q;
  logic [2:0]            sursp_q, sdop_q;
  logic                  rdy_q, sdvld_q, sdnew_q, cuvld_q, err_q;
  logic                  hit_eff, to_clr, to_inc, to_lim;

  assign hit_eff = lkup_hit && (blk_curSt != INVALID);
  assign to_clr  = (state_q == REQ_SDREQ) && sdreq_ready;
  assign to_inc  = (state_q == REQ_WAIT_SURSP) && !sursp_valid;

  l1_req_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (to_clr),
    .inc_i (to_inc),
    .lim_o (to_lim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REQ_IDLE;
      op_q     <= 1'b0;
      addr_q   <= '0;
      status_q <= '0;
      sursp_q  <= '0;
      sdop_q   <= '0;
      rdy_q    <= 1'b0;
      sdvld_q  <= 1'b0;
      sdnew_q  <= 1'b0;
      cuvld_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sdnew_q <= 1'b0;
      case (state_q)
        REQ_IDLE: begin
          rdy_q <= 1'b1;
          if (rdy_q && cpreq_valid) begin
            op_q    <= cpreq_op;
            addr_q  <= cpreq_addr;
            sursp_q <= '0;
            rdy_q   <= 1'b0;
            state_q <= REQ_LOOKUP;
          end
        end
        REQ_LOOKUP: begin
          status_q <= req_status_enc(op_q, hit_eff);
          // A write to a SHARED copy must invalidate the other sharers first.
          if (!hit_eff || (op_q && blk_curSt == SHARED)) begin
            sdvld_q <= 1'b1;
            sdnew_q <= 1'b1;
            state_q <= REQ_SDREQ;
          end else begin
            cuvld_q <= 1'b1;
            state_q <= REQ_RSP_CURSP;
          end
        end
        REQ_SDREQ: begin
          if (sdnew_q) sdop_q <= init_sdreq;
          if (sdreq_ready) begin
            sdvld_q <= 1'b0;
            state_q <= REQ_WAIT_SURSP;
          end
        end
        REQ_WAIT_SURSP: begin
          if (sursp_valid) begin
            sursp_q <= sursp_in;
            cuvld_q <= 1'b1;
            state_q <= REQ_RSP_CURSP;
          end else if (to_lim) begin
            err_q   <= 1'b1;
            state_q <= REQ_ERR;
          end
        end
        REQ_RSP_CURSP: begin
          if (cursp_ready) begin
            cuvld_q  <= 1'b0;
            status_q <= '0;
            rdy_q    <= 1'b1;
            state_q  <= REQ_IDLE;
          end
        end
        REQ_ERR: err_q <= 1'b1;
        default: begin
          sdvld_q  <= 1'b0;
          cuvld_q  <= 1'b0;
          status_q <= '0;
          state_q  <= REQ_IDLE;
        end
      endcase
    end
  end

  // The FSM only sees the new req_status in the first SDREQ cycle, so that cycle
  // forwards init_sdreq directly while the register captures it for the rest of the stall.
  assign sdreq_op    = sdnew_q ? init_sdreq : sdop_q;
  assign sdreq_valid = sdvld_q;
  assign sdreq_addr  = addr_q;
  assign cpreq_ready = rdy_q;
  assign req_status  = status_q;
  assign req_curSt   = state_q;
  assign sursp_rsp   = sursp_q;
  assign cursp_valid = cuvld_q;
  assign blk_wr_en   = cuvld_q && cursp_ready;
  assign blk_wr_st   = cuvld_q ? blk_nxtSt : INVALID;
  assign timeout_err = err_q;

endmodule
